matdet4_seq: RTL and testbench
==============================

Name: matdet4_seq

Overview:
- Sequential 4x4 determinant engine. It time-multiplexes one combinational 3x3 determinant unit across the four row-0 cofactors and accumulates the signed products.
- Replaces the fully unrolled 4x4 datapath (four 3x3 units) where area matters more than throughput.
- Sits between a matrix producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, element and result width; all arithmetic is modulo 2^DATA_WIDTH.
- MATRIX_SIZE, 16, element count of the input matrix; fixed at 16 (4x4), any other value is unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers a matrix.
- in_ready  out  1  engine can accept a matrix.
- a  in  MATRIX_SIZE*DATA_WIDTH  matrix, row-major; element (r,c) at a[(4r+c)*DATA_WIDTH +: DATA_WIDTH], so element (0,0) is in the LSBs.
- out_valid  out  1  det holds a completed result.
- out_ready  in  1  consumer accepts the result.
- det  out  DATA_WIDTH  determinant modulo 2^DATA_WIDTH.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset: rst sampled high on a clk edge forces the following, regardless of state, including mid-CALC and mid-DONE:
  - state=IDLE, in_ready=1, out_valid=0, det=0, busy=0.
  - accumulator=0, column counter=0.
  - the latched matrix is left unchanged (don't-care).
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a into matrix register m, clear accumulator, set col=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle, for col j:
    - minor M_j = rows 1..3 of m with column j removed, packed row-major with its first element in the LSBs.
    - term = m(0,j) * det3(M_j), truncated to DATA_WIDTH.
    - acc = acc + term for even j, acc - term for odd j.
    - after j=3, go to DONE and load det with the final acc value (i.e. including the j=3 term).
  - DONE: out_valid=1, det stable. On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency and throughput:
  - accept at edge 0; CALC runs on edges 1..4; out_valid is high from after edge 4.
  - 4 cycles accept-to-valid.
  - minimum 6-cycle spacing between accepts when out_ready is tied high.
- Handshake rules:
  - in_ready is combinational from the state only, never from in_valid.
  - a is sampled only on the accept edge; later changes to a have no effect on the operation in flight.
  - det and out_valid hold unchanged under backpressure.
  - in_valid during CALC or DONE is ignored; the producer must hold it.
  - out_ready while out_valid=0 has no effect.
- Arithmetic:
  - all products, sums and differences are truncated to DATA_WIDTH bits, unsigned wrap-around.
  - the result is congruent to the true signed determinant modulo 2^DATA_WIDTH.
- det is 0 outside DONE until the first completion; after that it holds the last result until reset or the next DONE load.

Decomposition:
- Shared package:
  - state enum (IDLE, CALC, DONE).
  - column counter width constant (2).
  - element index function idx(r,c) = 4r+c.
  - minor-column lookup (for j: the three kept columns).
- Sub-module det3_comb: purely combinational 3x3 determinant over DATA_WIDTH, using the same packing as above and cofactor expansion along row 0. The parent instantiates exactly one.
- Minor selection is a 4:1 mux in the parent, driven by col.

Test Plan:
- Identity matrix, out_ready=1 -> det=0x01. out_valid rises exactly 4 cycles after the accept and in_ready returns after the out handshake.
- diag(2,3,4,5) -> det=0x78 (120). diag(4,4,4,4) -> det=0x00 (256 wraps).
- Identity with columns 0 and 1 swapped -> det=0xFF (-1). All-ones matrix -> det=0x00.
- Backpressure:
  - hold out_ready=0 for 3 cycles after out_valid -> det and out_valid stable, in_ready=0, a changed during the wait is ignored.
  - raise out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst on the 2nd CALC cycle -> next cycle IDLE, out_valid=0, det=0, in_ready=1. A following identity matrix then yields 0x01.
- Back-to-back: stream diag(2,3,4,5) then identity with in_valid held and out_ready=1 -> results 0x78 then 0x01, accepts spaced 6 cycles apart.

Source files
------------

// File: rtl/matdet4_seq_pkg.sv
// Shared types and helpers for the sequential 4x4 determinant engine.
// Holds the FSM state enum, the column counter width and index helpers.
package matdet4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int COL_W = 2;
  localparam int N     = 4;

  // Flat element index of (r,c) in a row-major 4x4 matrix.
  function automatic int idx(input int r, input int c);
    return N * r + c;
  endfunction

  // k-th surviving column (k=0..2) once column j is removed.
  function automatic int kept_col(input int j, input int k);
    return (k < j) ? k : k + 1;
  endfunction

endpackage

// File: rtl/matdet4_seq_det3_comb.sv
// Combinational 3x3 determinant, modulo 2^DATA_WIDTH, row-0 expansion.
// Ports: i_m = 9 elements row-major, (0,0) in LSBs; o_det = result.
module det3_comb
  import matdet4_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [9*DATA_WIDTH-1:0] i_m,
  output logic [DATA_WIDTH-1:0]   o_det
);

  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] w_e [9];

  for (genvar g = 0; g < 9; g++) begin : g_el
    assign w_e[g] = i_m[g*DW +: DW];
  end

  logic [DW-1:0] w_c0;
  logic [DW-1:0] w_c1;
  logic [DW-1:0] w_c2;

  // 2x2 cofactors of row 0; operands and results all DW wide,
  // so every product and difference wraps naturally.
  assign w_c0 = w_e[4] * w_e[8] - w_e[5] * w_e[7];
  assign w_c1 = w_e[3] * w_e[8] - w_e[5] * w_e[6];
  assign w_c2 = w_e[3] * w_e[7] - w_e[4] * w_e[6];

  assign o_det = w_e[0] * w_c0
               - w_e[1] * w_c1
               + w_e[2] * w_c2;

endmodule

// File: rtl/matdet4_seq.sv
// Sequential 4x4 determinant: one 3x3 unit reused over the 4 row-0 cofactors.
// Ports: clk, rst (sync, active high), in_valid/in_ready/a (matrix in),
// out_valid/out_ready/det (result out), busy (not IDLE).
module matdet4_seq
  import matdet4_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             det,
  output logic                              busy
);

  localparam int DW = DATA_WIDTH;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [MATRIX_SIZE*DW-1:0]     r_m;
  logic [DW-1:0]                 r_acc;
  logic [DW-1:0]                 r_det;
  logic [COL_W-1:0]              r_col;

  logic                          w_accept;
  logic                          w_last;
  logic [9*DW-1:0]               w_minors [4];
  logic [9*DW-1:0]               w_minor;
  logic [DW-1:0]                 w_m0j;
  logic [DW-1:0]                 w_d3;
  logic [DW-1:0]                 w_term;
  logic [DW-1:0]                 w_acc_nxt;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_col == COL_W'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Matrix is only captured on accept; its value after reset is irrelevant.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_m <= a;
    end
  end

  // All four candidate minors are pure wiring; col picks one.
  for (genvar j = 0; j < N; j++) begin : g_minor
    for (genvar r = 1; r < N; r++) begin : g_row
      for (genvar k = 0; k < 3; k++) begin : g_col
        assign w_minors[j][((r-1)*3+k)*DW +: DW] =
          r_m[idx(r, kept_col(j, k))*DW +: DW];
      end
    end
  end

  always_comb begin
    w_minor = w_minors[0];
    w_m0j   = r_m[idx(0, 0)*DW +: DW];
    unique case (r_col)
      2'd0: begin
        w_minor = w_minors[0];
        w_m0j   = r_m[idx(0, 0)*DW +: DW];
      end
      2'd1: begin
        w_minor = w_minors[1];
        w_m0j   = r_m[idx(0, 1)*DW +: DW];
      end
      2'd2: begin
        w_minor = w_minors[2];
        w_m0j   = r_m[idx(0, 2)*DW +: DW];
      end
      2'd3: begin
        w_minor = w_minors[3];
        w_m0j   = r_m[idx(0, 3)*DW +: DW];
      end
      default: begin
        w_minor = w_minors[0];
        w_m0j   = r_m[idx(0, 0)*DW +: DW];
      end
    endcase
  end

  det3_comb #(
    .DATA_WIDTH(DW)
  ) u_det3 (
    .i_m  (w_minor),
    .o_det(w_d3)
  );

  assign w_term = w_m0j * w_d3;

  // Cofactor sign alternates with column parity.
  assign w_acc_nxt = r_col[0] ? (r_acc - w_term)
                              : (r_acc + w_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_col <= '0;
      r_det <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_col <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_col <= r_col + 1'b1;
      if (w_last) begin
        r_det <= w_acc_nxt;
      end
    end
  end

  assign det = r_det;

endmodule

// File: tb/tb_matdet4_seq.sv
// Bench for matdet4_seq: Leibniz-formula reference, per-cycle compare,
// directed cases plus a randomized handshake/reset phase.
module tb_matdet4_seq;

  localparam int DW = 8;
  localparam int MS = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [MS*DW-1:0] a = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [DW-1:0]  det;

  always #5 clk = ~clk;

  matdet4_seq #(
    .DATA_WIDTH (DW),
    .MATRIX_SIZE(MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .det      (det),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Leibniz sum over all 24 permutations, exact in longint, then wrapped.
  function automatic logic [7:0] refdet(input logic [127:0] mm);
    longint s = 0;
    longint prod;
    int p [4];
    int inv;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < 4; l++) begin
            if (i != j && i != k && i != l &&
                j != k && j != l && k != l) begin
              p = '{i, j, k, l};
              inv = 0;
              for (int u = 0; u < 4; u++)
                for (int v = u + 1; v < 4; v++)
                  if (p[u] > p[v]) inv++;
              prod = 1;
              for (int r = 0; r < 4; r++)
                prod = prod * longint'(mm[(4*r+p[r])*8 +: 8]);
              s = (inv % 2 == 1) ? s - prod : s + prod;
            end
          end
    return s[7:0];
  endfunction

  function automatic logic [127:0] diag(input logic [7:0] d0, d1, d2, d3);
    logic [127:0] m = '0;
    m[0*8 +: 8]  = d0;
    m[5*8 +: 8]  = d1;
    m[10*8 +: 8] = d2;
    m[15*8 +: 8] = d3;
    return m;
  endfunction

  // Reference model: result-level view of accept, 4-cycle compute,
  // hold-until-taken and reset.
  bit         m_on = 1'b0;
  bit         m_idle = 1'b1;
  bit         m_valid = 1'b0;
  int         m_calc = 0;
  logic [7:0] m_det = '0;
  logic [7:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on    = 1'b1;
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_calc  = 0;
      m_det   = '0;
    end else if (m_on) begin
      if (m_idle) begin
        if (in_valid) begin
          m_pend = refdet(a);
          m_idle = 1'b0;
          m_calc = 4;
        end
      end else if (m_calc > 0) begin
        m_calc--;
        if (m_calc == 0) begin
          m_valid = 1'b1;
          m_det   = m_pend;
        end
      end else if (out_ready) begin
        got_q.push_back(det);
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_idle));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("det", 32'(det), 32'(m_det));
    end
  end

  task automatic send(input logic [127:0] mat);
    int n = 0;
    @(negedge clk);
    a = mat;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic drop_in();
    in_valid = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic expect_res(input string nm, input logic [7:0] exp);
    int n = 0;
    while (got_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else chk(nm, 32'(got_q.pop_front()), 32'(exp));
  endtask

  logic [127:0] ID, D2345, D4, SWAP, ONES;
  int lat;
  int a1;

  initial begin
    ID    = diag(8'd1, 8'd1, 8'd1, 8'd1);
    D2345 = diag(8'd2, 8'd3, 8'd4, 8'd5);
    D4    = diag(8'd4, 8'd4, 8'd4, 8'd4);
    SWAP  = '0;
    SWAP[1*8 +: 8]  = 8'd1;
    SWAP[4*8 +: 8]  = 8'd1;
    SWAP[10*8 +: 8] = 8'd1;
    SWAP[15*8 +: 8] = 8'd1;
    ONES  = {16{8'h01}};

    chk("ref_ident", 32'(refdet(ID)), 32'h01);
    chk("ref_diag2345", 32'(refdet(D2345)), 32'h78);
    chk("ref_diag4", 32'(refdet(D4)), 32'h00);
    chk("ref_swap", 32'(refdet(SWAP)), 32'hFF);
    chk("ref_ones", 32'(refdet(ONES)), 32'h00);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_det", 32'(det), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    out_ready = 1'b1;
    send(ID);
    drop_in();
    wait_valid(lat);
    chk("latency", 32'(lat), 32'd4);
    @(negedge clk);
    chk("ready_back", 32'(in_ready), 32'd1);
    expect_res("ident", 8'h01);

    send(D2345); drop_in(); expect_res("diag2345", 8'h78);
    send(D4);    drop_in(); expect_res("diag4", 8'h00);
    send(SWAP);  drop_in(); expect_res("swap01", 8'hFF);
    send(ONES);  drop_in(); expect_res("ones", 8'h00);

    out_ready = 1'b0;
    send(D2345);
    drop_in();
    wait_valid(lat);
    repeat (3) begin
      @(negedge clk);
      a = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_det", 32'(det), 32'h78);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    expect_res("bp_result", 8'h78);

    send(D2345);
    drop_in();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_det", 32'(det), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    send(ID); drop_in(); expect_res("post_rst_ident", 8'h01);
    chk("no_stale_result", 32'(got_q.size()), 32'd0);

    send(D2345);
    a1 = acc_cyc;
    send(ID);
    chk("b2b_spacing", 32'(acc_cyc - a1), 32'd6);
    drop_in();
    expect_res("b2b_first", 8'h78);
    expect_res("b2b_second", 8'h01);

    repeat (800) begin
      @(negedge clk);
      in_valid  = ($urandom % 2) == 0;
      a         = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 150) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
